// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART receiver and transmitter.
// Optional build macro used by uart_receiver: UART_RX_MAJORITY_EN.
package uart_pkg;

    // Receiver frame-tracking states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // 100 MHz / 115200 baud.
    localparam logic [15:0] DEFAULT_WTIME   = 16'h364;
    localparam int          UART_DATA_W     = 8;
    localparam logic        UART_STOP_LEVEL = 1'b1;

    // Two-out-of-three vote, used to reject single-cycle line glitches.
    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// uart_receiver_if: received-byte stream (valid/ready) plus error pulses.
// master = the receiver producing bytes, slave = the consumer.
interface uart_receiver_if;
    import uart_pkg::*;

    logic                   valid;
    logic [UART_DATA_W-1:0] data;
    logic                   ready;
    logic                   ferr;
    logic                   ovr;

    modport master (
        output valid,
        output data,
        output ferr,
        output ovr,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  ferr,
        input  ovr,
        output ready
    );

endinterface

// File: rtl/uart_sync.sv
// uart_sync: multi-flop synchronizer for one asynchronous input bit.
// Resets to RESET_VAL so an idle-high line does not show a false edge.
module uart_sync #(
    parameter int   DEPTH     = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sync_q;
    logic [DEPTH-1:0] sync_d;

    // Shift the raw input into the bottom of the chain.
    always_comb begin
        sync_d = {sync_q[DEPTH-2:0], d};
    end

    // Synchronizer chain registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {DEPTH{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[DEPTH-1];

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 LSB-first UART receiver with valid/ready output,
// framing-error and overrun pulses.
// Build macro UART_RX_MAJORITY_EN: when defined, every bit sample is the
// majority of the last three synchronized line values (needs WTIME >= 8).
module uart_receiver
    import uart_pkg::*;
#(
    parameter logic [15:0] WTIME = DEFAULT_WTIME
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx,
    uart_receiver_if.master out_if,
    output logic            busy
);

    // Start-bit centre and full-bit sample points.
    localparam logic [15:0] HALF_M1 = (WTIME >> 1) - 16'd1;
    localparam logic [15:0] FULL_M1 = WTIME - 16'd1;

    logic rx_s;
    logic sample;

    rx_state_t              state_q, state_d;
    logic                   rx_d_q, rx_d_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [UART_DATA_W-1:0] shreg_q, shreg_d;
    logic [UART_DATA_W-1:0] data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic                   ovr_q, ovr_d;

    uart_sync #(
        .DEPTH     (2),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q, hist_d;

    // Keep the two previous synchronized samples for the vote.
    always_comb begin
        hist_d = {hist_q[0], rx_s};
    end

    // Vote history; reset to idle level.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign sample = maj3({hist_q, rx_s});
`else
    assign sample = rx_s;
`endif

    // Next-state logic: frame tracking, bit sampling and output handshake.
    always_comb begin
        state_d = state_q;
        rx_d_d  = rx_s;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        // The consumer taking the byte clears valid unless a new byte lands.
        valid_d = valid_q && !out_if.ready;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // Falling edge of the synchronized line starts a frame.
                if (rx_d_q && !rx_s) begin
                    state_d = START;
                    cnt_d   = 16'd0;
                end
            end

            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = 16'd0;
                    if (sample) begin
                        // Line back high at start-bit centre: a glitch.
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        idx_d   = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = 16'd0;
                    shreg_d = {sample, shreg_q[UART_DATA_W-1:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            STOP: begin
                if (cnt_q == FULL_M1) begin
                    // Leave at mid-stop so a back-to-back start edge is seen.
                    cnt_d   = 16'd0;
                    state_d = IDLE;
                    if (sample == UART_STOP_LEVEL) begin
                        if (valid_q && !out_if.ready) begin
                            // Previous byte still held: drop the new one.
                            ovr_d = 1'b1;
                        end else begin
                            data_d  = shreg_q;
                            valid_d = 1'b1;
                        end
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rx_d_q  <= 1'b1;
            cnt_q   <= 16'd0;
            idx_q   <= 3'd0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rx_d_q  <= rx_d_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign out_if.valid = valid_q;
    assign out_if.data  = data_q;
    assign out_if.ferr  = ferr_q;
    assign out_if.ovr   = ovr_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: scoreboard bench for uart_receiver at WTIME=16.
module tb_uart_receiver;
    import uart_pkg::*;

    localparam logic [15:0] W   = 16'd16;
    localparam int          WI  = 16;
    localparam int          H   = WI / 2;
    localparam int          LAT = 3 + H + 9 * WI;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    logic busy;

    uart_receiver_if bus ();

    uart_receiver #(.WTIME(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .rx     (rx),
        .out_if (bus.master),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard queues: expected bytes from stimulus, observed accepts.
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    int   ferr_cnt       = 0;
    int   ovr_cnt        = 0;
    int   busy_rise_cnt  = 0;
    int   busy_fall_cnt  = 0;
    int   first_rise_cyc = -1;
    logic valid_prev     = 1'b0;
    logic busy_prev      = 1'b0;

    // Monitor: sample away from the active edge and log DUT events.
    always @(negedge clk) begin
        if (bus.valid === 1'b1 && bus.ready === 1'b1) got_q.push_back(bus.data);
        if (bus.ferr === 1'b1) ferr_cnt <= ferr_cnt + 1;
        if (bus.ovr === 1'b1) ovr_cnt <= ovr_cnt + 1;
        if (bus.valid === 1'b1 && !valid_prev && first_rise_cyc < 0) first_rise_cyc <= cyc;
        if (busy === 1'b1 && !busy_prev) busy_rise_cnt <= busy_rise_cnt + 1;
        if (busy === 1'b0 && busy_prev) busy_fall_cnt <= busy_fall_cnt + 1;
        valid_prev <= (bus.valid === 1'b1);
        busy_prev  <= (busy === 1'b1);
    end

    // Drive one frame; call 1 time unit after a rising edge.
    // glitch_bit >= 0 inverts that data bit for one cycle at its centre.
    task automatic send_frame(input logic [7:0] b, input logic stop_lvl,
                              input int glitch_bit, output int fall_cyc);
        fall_cyc = cyc;
        rx = 1'b0;
        repeat (WI) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (i == glitch_bit) begin
                repeat (H) @(posedge clk);
                #1 rx = ~b[i];
                @(posedge clk);
                #1 rx = b[i];
                repeat (WI - H - 1) @(posedge clk);
                #1;
            end else begin
                repeat (WI) @(posedge clk);
                #1;
            end
        end
        rx = stop_lvl;
        repeat (WI) @(posedge clk);
        #1 rx = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx  = 1'b1;
        bus.ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (bus.valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b want=0", bus.valid); end
        vectors++; if (bus.data !== 8'h00) begin miscompares++; $display("FAIL reset_data got=%h want=00", bus.data); end
        vectors++; if (bus.ferr !== 1'b0) begin miscompares++; $display("FAIL reset_ferr got=%b want=0", bus.ferr); end
        vectors++; if (bus.ovr !== 1'b0) begin miscompares++; $display("FAIL reset_ovr got=%b want=0", bus.ovr); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b want=0", busy); end
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        $display("reset released at cycle %0d", cyc);
    endtask

    task automatic test_loopback;
        int fc, f0, o0, lat;
        logic [7:0] g, e;
        f0 = ferr_cnt; o0 = ovr_cnt;
        exp_q.push_back(8'hAA);
        send_frame(8'hAA, 1'b1, -1, fc);
        repeat (4) @(posedge clk);
        #1;
        lat = first_rise_cyc - fc;
        $display("loopback frame: first valid %0d cycles after rx fall", lat);
        vectors++; if (first_rise_cyc < 0 || lat < LAT - 2 || lat > LAT + 2) begin miscompares++; $display("FAIL loopback_latency got=%0d want=%0d+-2", lat, LAT); end
        vectors++; if (got_q.size() != 1) begin miscompares++; $display("FAIL loopback_count got=%0d want=1", got_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (got_q.size() == 0) begin miscompares++; $display("FAIL loopback_data got=none want=%h", e); end
            else begin
                g = got_q.pop_front();
                $display("accepted byte %h (expected %h)", g, e);
                if (g !== e) begin miscompares++; $display("FAIL loopback_data got=%h want=%h", g, e); end
            end
        end
        vectors++; if (ferr_cnt != f0 || ovr_cnt != o0) begin miscompares++; $display("FAIL loopback_flags ferr=%0d ovr=%0d want=0,0", ferr_cnt - f0, ovr_cnt - o0); end
        vectors++; if (bus.valid !== 1'b0) begin miscompares++; $display("FAIL loopback_valid_clear got=%b want=0", bus.valid); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] bytes[4];
        int fc, f0, o0, b0;
        logic [7:0] g, e;
        bytes[0] = 8'h55; bytes[1] = 8'hA5; bytes[2] = 8'h00; bytes[3] = 8'hFF;
        f0 = ferr_cnt; o0 = ovr_cnt; b0 = busy_fall_cnt;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(bytes[i]);
            send_frame(bytes[i], 1'b1, -1, fc);
        end
        repeat (4) @(posedge clk);
        #1;
        vectors++; if (got_q.size() != 4) begin miscompares++; $display("FAIL b2b_count got=%0d want=4", got_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (got_q.size() == 0) begin miscompares++; $display("FAIL b2b_data got=none want=%h", e); end
            else begin
                g = got_q.pop_front();
                $display("accepted byte %h (expected %h)", g, e);
                if (g !== e) begin miscompares++; $display("FAIL b2b_data got=%h want=%h", g, e); end
            end
        end
        vectors++; if (ferr_cnt != f0 || ovr_cnt != o0) begin miscompares++; $display("FAIL b2b_flags ferr=%0d ovr=%0d want=0,0", ferr_cnt - f0, ovr_cnt - o0); end
        vectors++; if (busy_fall_cnt - b0 != 4) begin miscompares++; $display("FAIL b2b_busy_falls got=%0d want=4", busy_fall_cnt - b0); end
    endtask

    task automatic test_overrun;
        int fc, o0;
        logic [7:0] g;
        o0 = ovr_cnt;
        bus.ready = 1'b0;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, -1, fc);
        send_frame(8'hC3, 1'b1, -1, fc);
        repeat (4) @(posedge clk);
        #1;
        $display("overrun: held byte %h valid=%b ovr pulses=%0d", bus.data, bus.valid, ovr_cnt - o0);
        vectors++; if (bus.valid !== 1'b1) begin miscompares++; $display("FAIL ovr_valid_held got=%b want=1", bus.valid); end
        vectors++; if (bus.data !== 8'h3C) begin miscompares++; $display("FAIL ovr_data_held got=%h want=3c", bus.data); end
        vectors++; if (ovr_cnt - o0 != 1) begin miscompares++; $display("FAIL ovr_pulses got=%0d want=1", ovr_cnt - o0); end
        vectors++; if (got_q.size() != 0) begin miscompares++; $display("FAIL ovr_no_accept got=%0d want=0", got_q.size()); end
        bus.ready = 1'b1;
        @(posedge clk);
        #1;
        vectors++; if (bus.valid !== 1'b0) begin miscompares++; $display("FAIL ovr_valid_after_accept got=%b want=0", bus.valid); end
        vectors++;
        if (got_q.size() != 1) begin miscompares++; $display("FAIL ovr_accept_count got=%0d want=1", got_q.size()); end
        else begin
            g = got_q.pop_front();
            $display("accepted byte %h (expected %h)", g, exp_q[0]);
            if (g !== exp_q[0]) begin miscompares++; $display("FAIL ovr_accept_data got=%h want=%h", g, exp_q[0]); end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_framing;
        int fc, f0;
        logic [7:0] g, e;
        f0 = ferr_cnt;
        send_frame(8'h81, 1'b0, -1, fc);
        repeat (2 * WI) @(posedge clk);
        #1;
        exp_q.push_back(8'h42);
        send_frame(8'h42, 1'b1, -1, fc);
        repeat (4) @(posedge clk);
        #1;
        $display("framing: ferr pulses=%0d accepts=%0d", ferr_cnt - f0, got_q.size());
        vectors++; if (ferr_cnt - f0 != 1) begin miscompares++; $display("FAIL ferr_pulses got=%0d want=1", ferr_cnt - f0); end
        vectors++; if (got_q.size() != 1) begin miscompares++; $display("FAIL ferr_accept_count got=%0d want=1", got_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (got_q.size() == 0) begin miscompares++; $display("FAIL ferr_next_data got=none want=%h", e); end
            else begin
                g = got_q.pop_front();
                $display("accepted byte %h (expected %h)", g, e);
                if (g !== e) begin miscompares++; $display("FAIL ferr_next_data got=%h want=%h", g, e); end
            end
        end
        got_q.delete();
    endtask

    task automatic test_glitch_and_reset;
        int fc, f0, br0;
        logic [7:0] g, e;
        f0 = ferr_cnt; br0 = busy_rise_cnt;
        rx = 1'b0;
        repeat (WI / 4) @(posedge clk);
        #1 rx = 1'b1;
        repeat (2 * WI) @(posedge clk);
        #1;
        $display("short pulse: busy rises=%0d accepts=%0d", busy_rise_cnt - br0, got_q.size());
        vectors++; if (busy_rise_cnt - br0 != 1) begin miscompares++; $display("FAIL glitch_busy_pulse got=%0d want=1", busy_rise_cnt - br0); end
        vectors++; if (got_q.size() != 0 || ferr_cnt != f0) begin miscompares++; $display("FAIL glitch_no_output accepts=%0d ferr=%0d want=0,0", got_q.size(), ferr_cnt - f0); end
        // Start bit plus three data bits, then reset in the middle of DATA.
        rx = 1'b0;
        repeat (WI) @(posedge clk);
        #1 rx = 1'b1;
        repeat (3 * WI) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        vectors++; if (busy !== 1'b0 || bus.valid !== 1'b0) begin miscompares++; $display("FAIL midreset_state busy=%b valid=%b want=0,0", busy, bus.valid); end
        repeat (2 * WI) @(posedge clk);
        #1;
        vectors++; if (got_q.size() != 0) begin miscompares++; $display("FAIL midreset_no_output got=%0d want=0", got_q.size()); end
        exp_q.push_back(8'h99);
        send_frame(8'h99, 1'b1, -1, fc);
        repeat (4) @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (got_q.size() == 0) begin miscompares++; $display("FAIL midreset_next_data got=none want=%h", e); end
            else begin
                g = got_q.pop_front();
                $display("accepted byte %h (expected %h)", g, e);
                if (g !== e) begin miscompares++; $display("FAIL midreset_next_data got=%h want=%h", g, e); end
            end
        end
        got_q.delete();
    endtask

    task automatic test_bit_glitch;
        int fc;
        logic [7:0] g, e;
`ifdef UART_RX_MAJORITY_EN
        exp_q.push_back(8'h00);
`else
        exp_q.push_back(8'h08);
`endif
        send_frame(8'h00, 1'b1, 3, fc);
        repeat (4) @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (got_q.size() == 0) begin miscompares++; $display("FAIL bitglitch_data got=none want=%h", e); end
            else begin
                g = got_q.pop_front();
                $display("accepted byte %h (expected %h)", g, e);
                if (g !== e) begin miscompares++; $display("FAIL bitglitch_data got=%h want=%h", g, e); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_back_to_back();
        test_overrun();
        test_framing();
        test_glitch_and_reset();
        test_bit_glitch();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
